// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Groups the raw front-panel button pins and the conditioned event outputs
//   of one button_conditioner instance.
//
//   Signals:
//     up_n, down_n, ok_n : raw active-low buttons, asynchronous to the clock
//     up, down, ok       : one-cycle active-high event pulses
//     held               : debounced pressed levels {ok, down, up}
//
//   Modports:
//     master : the panel side (drives buttons, consumes events)
//     slave  : the conditioner side
interface button_conditioner_if;
    logic       up_n;
    logic       down_n;
    logic       ok_n;
    logic       up;
    logic       down;
    logic       ok;
    logic [2:0] held;

    modport master (
        output up_n, down_n, ok_n,
        input  up, down, ok, held
    );

    modport slave (
        input  up_n, down_n, ok_n,
        output up, down, ok, held
    );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner
//   Turns the three raw active-low panel buttons (up, down, ok) into clean,
//   single-cycle, active-high event pulses. Each button goes through a 2-FF
//   synchronizer, a debounce filter and a press-edge detector. Up and down
//   additionally auto-repeat while held, and are muted while both are held.
//
//   Ports:
//     clk : system clock
//     rst : synchronous active-high reset
//     btn : button_conditioner_if.slave (raw buttons in, pulses/held out)
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000,
    parameter int REPEAT_EN       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  btn
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_PERIOD
    } rpt_state_t;

    // Bit order everywhere is {ok, down, up}.
    logic [2:0]      raw_n;
    logic [2:0]      sync_a;
    logic [2:0]      sync_b;
    logic [2:0]      pressed;
    logic [2:0]      deb;
    logic [2:0]      deb_d;
    logic [2:0]      rise;
    logic [DB_W-1:0] db_cnt [3];

    rpt_state_t       rpt_state      [2];
    rpt_state_t       rpt_state_next [2];
    logic [RPT_W-1:0] rpt_cnt        [2];
    logic [RPT_W-1:0] rpt_cnt_next   [2];
    logic [1:0]       rpt_fire;

    logic up_q;
    logic down_q;
    logic ok_q;

    assign raw_n   = {btn.ok_n, btn.down_n, btn.up_n};
    assign pressed = ~sync_b;
    assign rise    = deb & ~deb_d;

    // Synchronizers reset to the released (high) level so a button held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= raw_n;
            sync_b <= sync_a;
        end
    end

    // Debounce: the level must disagree with the accepted state for
    // DEBOUNCE_CYCLES consecutive edges before it is taken; any agreeing
    // edge restarts the count. deb_d keeps last cycle's state for edge
    // detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 3; i++) begin
                if (pressed[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= ~deb[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_ONE;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Repeat engine for up (0) and down (1). Entering RPT_DELAY restarts the
    // count, which happens both on a fresh press and on every conflict
    // cycle, so repeats resume a full delay after a conflict ends.
    always_comb begin
        rpt_fire = '0;
        for (int b = 0; b < 2; b++) begin
            rpt_state_next[b] = rpt_state[b];
            rpt_cnt_next[b]   = rpt_cnt[b];
            if (!deb[b] || (REPEAT_EN == 0)) begin
                rpt_state_next[b] = RPT_IDLE;
                rpt_cnt_next[b]   = '0;
            end else if (deb[1-b] || (rpt_state[b] == RPT_IDLE)) begin
                rpt_state_next[b] = RPT_DELAY;
                rpt_cnt_next[b]   = '0;
            end else if (rpt_cnt[b] == ((rpt_state[b] == RPT_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                rpt_fire[b]       = 1'b1;
                rpt_state_next[b] = RPT_PERIOD;
                rpt_cnt_next[b]   = '0;
            end else begin
                rpt_cnt_next[b]   = rpt_cnt[b] + RPT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                rpt_state[b] <= RPT_IDLE;
                rpt_cnt[b]   <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                rpt_state[b] <= rpt_state_next[b];
                rpt_cnt[b]   <= rpt_cnt_next[b];
            end
        end
    end

    // A press of up or down while the other is already held is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            ok_q   <= 1'b0;
        end else begin
            up_q   <= (rise[0] & ~deb[1]) | rpt_fire[0];
            down_q <= (rise[1] & ~deb[0]) | rpt_fire[1];
            ok_q   <= rise[2];
        end
    end

    // Outputs are masked while rst is high so nothing is reported during
    // reset, even in the cycle before the reset edge takes effect.
    assign btn.up   = up_q & ~rst;
    assign btn.down = down_q & ~rst;
    assign btn.ok   = ok_q & ~rst;
    assign btn.held = deb & {3{~rst}};

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Drives two button_conditioner instances (auto-repeat on and off) with
//   directed button sequences. A cycle-based behavioural model predicts
//   every output on every cycle; scenario checks pin pulse positions to
//   hand-computed offsets.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_conditioner_if bif0 ();
    button_conditioner_if bif1 ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .REPEAT_EN(1)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .btn(bif0)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .REPEAT_EN(0)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .btn(bif1)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Inputs as seen by the active edge
    logic [2:0] samp_raw = 3'b111;
    logic       samp_rst = 1'b1;

    always @(posedge clk) begin
        samp_raw <= {bif0.ok_n, bif0.down_n, bif0.up_n};
        samp_rst <= rst;
    end

    // Model state, bit order {ok, down, up}
    logic [2:0] h1, h2;
    logic [2:0] m_deb, m_prev;
    int         m_run [3];
    int         anchor [2][2];
    bit         avalid [2][2];
    logic [2:0] exp_pulse [2];
    int         edge_n      = 0;
    bit         model_valid = 1'b0;

    // Observed DUT events, stored as edge numbers
    int q_up0[$], q_up1[$], q_dn0[$], q_ok0[$], q_hup[$], q_hok[$];
    logic [2:0] last_held = 3'b000;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int qAt(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Advance the model by one active edge. A button is accepted once its
    // level, seen two edges late, has disagreed with the accepted state for
    // D edges in a row. Repeats are scheduled on absolute time from an
    // anchor edge: RD after the anchor, then every RP.
    task automatic stepModel();
        logic [2:0] old_deb;
        logic [2:0] lvl;
        logic [2:0] rise;
        int         el;
        bit         fire;
        edge_n++;
        if (samp_rst) begin
            h1 = 3'b111;
            h2 = 3'b111;
            m_deb  = 3'b000;
            m_prev = 3'b000;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            for (int k = 0; k < 2; k++) begin
                exp_pulse[k] = 3'b000;
                for (int b = 0; b < 2; b++) avalid[k][b] = 1'b0;
            end
            model_valid = 1'b1;
        end else begin
            old_deb = m_deb;
            lvl = ~h2;
            for (int i = 0; i < 3; i++) begin
                if (lvl[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_deb[i] = ~m_deb[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            h2 = h1;
            h1 = samp_raw;
            rise = old_deb & ~m_prev;
            for (int k = 0; k < 2; k++) begin
                exp_pulse[k] = {rise[2], rise[1] & ~old_deb[0], rise[0] & ~old_deb[1]};
                for (int b = 0; b < 2; b++) begin
                    fire = 1'b0;
                    if (!old_deb[b] || k == 1) begin
                        avalid[k][b] = 1'b0;
                    end else if (old_deb[1-b] || !avalid[k][b]) begin
                        anchor[k][b] = edge_n;
                        avalid[k][b] = 1'b1;
                    end else begin
                        el = edge_n - anchor[k][b];
                        fire = (el >= RD) && (((el - RD) % RP) == 0);
                    end
                    if (fire) exp_pulse[k][b] = 1'b1;
                end
            end
            m_prev = old_deb;
        end
    endtask

    // One compare per instance on every cycle, sampled at the falling edge
    initial begin
        logic [5:0] exp_vec;
        logic [5:0] act_vec;
        forever begin
            @(negedge clk);
            stepModel();
            if (model_valid) begin
                for (int k = 0; k < 2; k++) begin
                    exp_vec = rst ? 6'd0 : {exp_pulse[k][0], exp_pulse[k][1], exp_pulse[k][2], m_deb};
                    if (k == 0) act_vec = {bif0.up, bif0.down, bif0.ok, bif0.held};
                    else        act_vec = {bif1.up, bif1.down, bif1.ok, bif1.held};
                    checkOutput($sformatf("cycle%0d_inst%0d", edge_n, k), int'(act_vec), int'(exp_vec));
                end
            end
            if (bif0.up)   q_up0.push_back(edge_n);
            if (bif1.up)   q_up1.push_back(edge_n);
            if (bif0.down) q_dn0.push_back(edge_n);
            if (bif0.ok)   q_ok0.push_back(edge_n);
            if (bif0.held[0] && !last_held[0]) q_hup.push_back(edge_n);
            if (bif0.held[2] && !last_held[2]) q_hok.push_back(edge_n);
            last_held = bif0.held;
        end
    end

    task automatic applyStimulus(input logic [2:0] raw_n, input logic r);
        @(posedge clk);
        #1;
        rst = r;
        {bif0.ok_n, bif0.down_n, bif0.up_n} = raw_n;
        {bif1.ok_n, bif1.down_n, bif1.up_n} = raw_n;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearQueues();
        q_up0.delete(); q_up1.delete(); q_dn0.delete();
        q_ok0.delete(); q_hup.delete(); q_hok.delete();
    endtask

    initial begin
        int t0;
        int exp3 [7];
        int exp4 [5];
        int exp5 [6];
        exp3 = '{7, 17, 22, 27, 32, 37, 42};
        exp4 = '{7, 17, 22, 56, 61};
        exp5 = '{7, 17, 22, 32, 42, 47};

        {bif0.ok_n, bif0.down_n, bif0.up_n} = 3'b111;
        {bif1.ok_n, bif1.down_n, bif1.up_n} = 3'b111;

        // Clean press of up after a two-cycle reset
        applyStimulus(3'b111, 1'b1);
        applyStimulus(3'b111, 1'b1);
        applyStimulus(3'b111, 1'b0);
        idle(3);
        clearQueues();
        applyStimulus(3'b110, 1'b0);
        t0 = edge_n + 1;
        idle(29);
        applyStimulus(3'b111, 1'b0);
        idle(20);
        checkOutput("s1_up_first_offset", qAt(q_up0, 0) - t0, 7);
        checkOutput("s1_held_up_offset", qAt(q_hup, 0) - t0, 6);
        checkOutput("s1_norepeat_up_count", q_up1.size(), 1);
        checkOutput("s1_down_count", q_dn0.size(), 0);
        checkOutput("s1_ok_count", q_ok0.size(), 0);

        // Bouncing ok, then a stable press
        clearQueues();
        applyStimulus(3'b011, 1'b0);
        t0 = edge_n + 1;
        for (int c = 1; c < 20; c++) begin
            applyStimulus(((c / 2) % 2 == 1) ? 3'b111 : 3'b011, 1'b0);
        end
        applyStimulus(3'b011, 1'b0);
        idle(29);
        applyStimulus(3'b111, 1'b0);
        idle(20);
        checkOutput("s2_ok_count", q_ok0.size(), 1);
        checkOutput("s2_ok_offset", qAt(q_ok0, 0) - t0, 27);
        checkOutput("s2_held_ok_rises", q_hok.size(), 1);

        // Auto-repeat on down
        clearQueues();
        applyStimulus(3'b101, 1'b0);
        t0 = edge_n + 1;
        idle(39);
        applyStimulus(3'b111, 1'b0);
        idle(20);
        checkOutput("s3_down_count", q_dn0.size(), 7);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("s3_down_offset%0d", i), qAt(q_dn0, i) - t0, exp3[i]);
        end

        // Up repeating, down pressed then released
        clearQueues();
        applyStimulus(3'b110, 1'b0);
        t0 = edge_n + 1;
        idle(19);
        applyStimulus(3'b100, 1'b0);
        idle(19);
        applyStimulus(3'b110, 1'b0);
        idle(17);
        applyStimulus(3'b111, 1'b0);
        idle(25);
        checkOutput("s4_up_count", q_up0.size(), 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("s4_up_offset%0d", i), qAt(q_up0, i) - t0, exp4[i]);
        end
        checkOutput("s4_down_count", q_dn0.size(), 0);

        // Reset while up is held and repeating
        clearQueues();
        applyStimulus(3'b110, 1'b0);
        t0 = edge_n + 1;
        idle(23);
        applyStimulus(3'b110, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("s5_outputs_in_reset", int'({bif0.up, bif0.down, bif0.ok, bif0.held}), 0);
        applyStimulus(3'b110, 1'b0);
        idle(18);
        applyStimulus(3'b111, 1'b0);
        idle(20);
        checkOutput("s5_up_count", q_up0.size(), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("s5_up_offset%0d", i), qAt(q_up0, i) - t0, exp5[i]);
        end

        // Repeat disabled: one pulse for a long hold
        clearQueues();
        applyStimulus(3'b110, 1'b0);
        t0 = edge_n + 1;
        idle(39);
        applyStimulus(3'b111, 1'b0);
        idle(20);
        checkOutput("s6_norepeat_count", q_up1.size(), 1);
        checkOutput("s6_norepeat_offset", qAt(q_up1, 0) - t0, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions the three raw active-low push-buttons (up, down, ok) of the 4-bit divider front panel. It produces clean, single-cycle, active-high event pulses for the divider's operand-entry logic. Per button: 2-FF synchronizer, debounce filter, and press-edge detector. Up and down also get hold-to-repeat. Sits between the board pins and the divider; one instance per panel.

Parameters:
DEBOUNCE_CYCLES, 120000, consecutive cycles a synchronized level must stay stable before it is accepted (10 ms at 12 MHz); minimum 1
REPEAT_DELAY, 6000000, cycles from the initial press pulse to the first auto-repeat pulse (0.5 s)
REPEAT_PERIOD, 1200000, cycles between subsequent auto-repeat pulses (0.1 s)
REPEAT_EN, 1, 1 enables auto-repeat on up/down; 0 disables it; ok never repeats

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
up_n  input  1  raw up button, active-low, asynchronous to clk
down_n  input  1  raw down button, active-low, asynchronous
ok_n  input  1  raw ok button, active-low, asynchronous
up  output  1  one-cycle pulse per accepted up press or repeat
down  output  1  one-cycle pulse per accepted down press or repeat
ok  output  1  one-cycle pulse per accepted ok press
held  output  3  debounced pressed levels {ok, down, up}, active-high

Behaviour:
- Single clock domain: clk. Reset: rst sampled on the rising edge of clk; active-high; synchronous only.
- Reset values:
  - synchronizer FFs = 1 (released)
  - debounced states = 0
  - all counters = 0
  - up/down/ok = 0
  - held = 3'b000
- Synchronizer: per button, two FFs, then inverted to a pressed level.
- Debounce:
  - Per-button counter increments on every edge where the synchronized level differs from the debounced state.
  - Counter clears to 0 on any edge where the two agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced state toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are fully rejected.
  - Counter width = clog2(DEBOUNCE_CYCLES+1).
- Latency: with a clean, stable press starting before edge E1, the press pulse is high during the cycle after edge E1+DEBOUNCE_CYCLES+2. Release is filtered identically but emits no pulse.
- Press pulse:
  - Registered.
  - High for exactly one cycle, on the cycle after the debounced state rises 0->1.
- Up/down conflict:
  - While both up and down are debounced-pressed, no up/down press or repeat pulses are emitted.
  - An up/down rising edge that occurs while the other is held is discarded, not deferred.
  - ok is independent of up/down at all times.
- Auto-repeat (REPEAT_EN=1, up/down only):
  - Repeat counter clears on the initial press pulse and counts while the button is held with no conflict.
  - First repeat pulse fires REPEAT_DELAY cycles after the initial pulse; then one pulse every REPEAT_PERIOD cycles.
  - Debounced release stops repeats immediately and clears the counter.
  - Conflict clears the counter. When the conflict ends with one button still held, repeats resume REPEAT_DELAY cycles later; no fresh press pulse is emitted.
- held: equals the debounced states directly, with no extra register stage.
- Reset mid-operation: all state is discarded. A button held through rst deassertion is treated as a new press and emits its pulse with the latency above, measured from the first edge after deassertion.
- Output pulses never exceed one cycle and never occur while rst=1.

Test Plan:
Override DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5 for all scenarios.
1. Clean press: rst=1 for 2 cycles; up_n 1->0 held 30 cycles -> up pulses once, 7 cycles after first low sample; held[0]=1 from the prior cycle; down=ok=0 throughout.
2. Bounce rejection: ok_n toggles 0/1 every 2 cycles for 20 cycles, then stays 0 -> zero ok pulses during bouncing; exactly one pulse after the level settles; held[2] rises once.
3. Auto-repeat: down_n held low 40 cycles -> pulses at t, t+10, t+15, t+20, t+25, t+30, t+35 (t = initial pulse); after release, no further pulses.
4. Conflict: up held until repeating, then down pressed -> up repeats stop and no down pulse; release down -> up repeat resumes 10 cycles after down's debounced release.
5. Reset mid-hold: up held and repeating, rst asserted 1 cycle -> all outputs 0 during rst; a fresh up pulse appears 7 cycles after deassertion.
6. REPEAT_EN=0: up held 40 cycles -> exactly one up pulse.
